// File: rtl/output_argmax_stream.sv
// rtl/output_argmax_stream.sv - streaming argmax over one vector of signed class scores
// Reports the winning index, its score and whether it beats the runner-up by MARGIN.
module output_argmax_stream #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASS   = 10,
  parameter int FIRST_CLASS = 1,
  parameter int TIE_HIGH    = 1,
  parameter int MARGIN      = 16,
  localparam int IDX_W      = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_score,
  output logic              out_confident
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [IDX_W-1:0]         LAST      = IDX_W'(NUM_CLASS - 1);
  localparam logic [IDX_W-1:0]         FIRST_IDX = IDX_W'(FIRST_CLASS);
  localparam logic signed [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]          MARGIN_V  = (DATA_W+1)'(MARGIN);

  state_t                     state, state_n;
  logic                       rdy_q;
  logic                       accept;
  logic                       last_beat;
  logic [IDX_W-1:0]           cnt;
  logic signed [DATA_W-1:0]   best, second, score;
  logic [IDX_W-1:0]           best_idx;
  logic                       has_two;
  logic signed [DATA_W-1:0]   upd_best, upd_second;
  logic [IDX_W-1:0]           upd_idx;
  logic                       upd_two;
  logic signed [DATA_W:0]     diff;
  logic                       conf_n;

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy_q && (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST);
  assign score     = $signed(in_data);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (NUM_CLASS == 1) ? DONE : ACC;
      ACC:  if (accept && last_beat) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Running best/second including the beat on in_data this cycle
  always_comb begin
    upd_best   = best;
    upd_second = second;
    upd_idx    = best_idx;
    upd_two    = has_two;
    if (cnt >= FIRST_IDX) begin
      if (cnt == FIRST_IDX) begin
        upd_best   = score;
        upd_second = MOST_NEG;
        upd_idx    = cnt;
        upd_two    = 1'b0;
      end else begin
        upd_two = 1'b1;
        if ((TIE_HIGH != 0) ? (score >= best) : (score > best)) begin
          upd_best   = score;
          upd_second = best;
          upd_idx    = cnt;
        end else if (score > second) begin
          upd_second = score;
        end
      end
    end
    // One extra bit so the full signed range difference cannot wrap
    diff   = {upd_best[DATA_W-1], upd_best} - {upd_second[DATA_W-1], upd_second};
    conf_n = !upd_two || ($unsigned(diff) >= MARGIN_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q         <= 1'b0;
      cnt           <= '0;
      best          <= '0;
      second        <= '0;
      best_idx      <= '0;
      has_two       <= 1'b0;
      out_index     <= '0;
      out_score     <= '0;
      out_confident <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        cnt     <= '0;
        has_two <= 1'b0;
      end else if (accept) begin
        cnt      <= last_beat ? '0 : cnt + 1'b1;
        best     <= upd_best;
        second   <= upd_second;
        best_idx <= upd_idx;
        has_two  <= upd_two;
        if (last_beat) begin
          out_index     <= upd_idx;
          out_score     <= upd_best;
          out_confident <= conf_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_argmax_stream.sv
// tb/tb_output_argmax_stream.sv - directed self-checking bench for output_argmax_stream
module tb_output_argmax_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_confident;
  logic [3:0]  out_index;
  logic [15:0] out_score;
  logic        in_ready_lo, out_valid_lo, out_confident_lo;
  logic [3:0]  out_index_lo;
  logic [15:0] out_score_lo;

  int passed = 0;
  int total  = 0;

  output_argmax_stream #(.DATA_W(16), .NUM_CLASS(10), .FIRST_CLASS(1), .TIE_HIGH(1), .MARGIN(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_score(out_score), .out_confident(out_confident)
  );

  output_argmax_stream #(.DATA_W(16), .NUM_CLASS(10), .FIRST_CLASS(1), .TIE_HIGH(0), .MARGIN(16)) dut_lo (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_lo),
    .in_data(in_data), .out_valid(out_valid_lo), .out_ready(out_ready), .out_index(out_index_lo),
    .out_score(out_score_lo), .out_confident(out_confident_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] v[10], input int n);
    for (int i = 0; i < n; i++) beat(v[i]);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [15:0] va [10] = '{16'd1000, 16'd0, 16'd5, 16'd3, 16'd9, 16'd2, 16'd50, 16'd200, 16'd40, 16'd7};
  logic [15:0] vt [10] = '{16'd0, 16'd0, 16'd0, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd0};
  logic [15:0] vn [10] = '{16'd0, 16'hFF9C, 16'hFFFB, 16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C, 16'hFF9C};
  logic [15:0] vx [10] = '{16'd0, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_index", {28'd0, out_index}, 32'd0);
    chk("rst_out_score", {16'd0, out_score}, 32'd0);
    chk("rst_out_conf", {31'd0, out_confident}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic vector, then DONE hold with out_ready low and beats offered
    send(va, 9);
    chk("a_not_yet_valid", {31'd0, out_valid}, 32'd0);
    beat(va[9]);
    chk("a_valid", {31'd0, out_valid}, 32'd1);
    chk("a_index", {28'd0, out_index}, 32'd7);
    chk("a_score", {16'd0, out_score}, 32'd200);
    chk("a_conf", {31'd0, out_confident}, 32'd1);
    chk("a_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h7000 + 16'(i);
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_index", {28'd0, out_index}, 32'd7);
      chk("hold_score", {16'd0, out_score}, 32'd200);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    take("a");
    chk("a_idle_ready", {31'd0, in_ready}, 32'd1);

    // Tie between class 3 and class 8
    send(vt, 10);
    chk("tie_hi_index", {28'd0, out_index}, 32'd8);
    chk("tie_hi_conf", {31'd0, out_confident}, 32'd0);
    chk("tie_lo_index", {28'd0, out_index_lo}, 32'd3);
    chk("tie_lo_conf", {31'd0, out_confident_lo}, 32'd0);
    take("tie");

    send(vn, 10);
    chk("neg_index", {28'd0, out_index}, 32'd2);
    chk("neg_score", {16'd0, out_score}, 32'h0000FFFB);
    chk("neg_conf", {31'd0, out_confident}, 32'd1);
    take("neg");

    send(vx, 10);
    chk("ext_index", {28'd0, out_index}, 32'd1);
    chk("ext_score", {16'd0, out_score}, 32'h00007FFF);
    chk("ext_conf", {31'd0, out_confident}, 32'd1);
    take("ext");

    // Flush mid-vector, then a clean vector
    send(vx, 4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    send(va, 10);
    chk("fl_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_index", {28'd0, out_index}, 32'd7);
    chk("fl_score", {16'd0, out_score}, 32'd200);
    take("fl");

    // Flush coincident with the last beat discards the vector
    send(va, 9);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = va[9];
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl9_no_valid", {31'd0, out_valid}, 32'd0);
    chk("fl9_ready", {31'd0, in_ready}, 32'd1);
    send(vn, 10);
    chk("fl9_next_index", {28'd0, out_index}, 32'd2);
    chk("fl9_next_score", {16'd0, out_score}, 32'h0000FFFB);
    take("fl9");

    // Asynchronous reset mid-vector
    send(vx, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_index", {28'd0, out_index}, 32'd0);
    chk("mid_rst_score", {16'd0, out_score}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(va, 10);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_index", {28'd0, out_index}, 32'd7);
    chk("post_rst_score", {16'd0, out_score}, 32'd200);
    chk("post_rst_conf", {31'd0, out_confident}, 32'd1);
    take("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
